tag_reorder_collector: RTL

TAG_REORDER_COLLECTOR -- requirements
Module: tag_reorder_collector

---
 rtl/tag_reorder_collector.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tag_reorder_collector.sv
// Reorders out-of-order per-tag results into allocation order; result->out_valid is 2 cycles (1 with RCOL_BYPASS_EN).
// Output is held while out_valid && !out_ready; alloc_ready drops while the order queue holds TAG_SIZE tags.
module tag_reorder_collector #(
    parameter int WIDTH     = 32,
    parameter int TAG_SIZE  = 16,
    parameter int DIV_COUNT = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 alloc_valid,
    input  logic [TAG_SIZE-1:0]                  alloc_tag,
    output logic                                 alloc_ready,
    input  logic [DIV_COUNT-1:0]                 res_valid,
    input  logic [DIV_COUNT-1:0][TAG_SIZE-1:0]   res_tag,
    input  logic [DIV_COUNT-1:0][3*WIDTH-1:0]    res_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TAG_SIZE-1:0]                  out_tag,
    output logic [3*WIDTH-1:0]                   out_data,
    output logic [TAG_SIZE-1:0]                  tag_free,
    output logic                                 err
);
    localparam int PW = (TAG_SIZE > 1) ? $clog2(TAG_SIZE) : 1;
    localparam int CW = $clog2(TAG_SIZE + 1);
    localparam int DW = 3 * WIDTH;

    logic [TAG_SIZE-1:0] order_q [TAG_SIZE];
    logic [DW-1:0]       slot [TAG_SIZE];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [TAG_SIZE-1:0] outstanding, filled;

    function automatic logic is_onehot(input logic [TAG_SIZE-1:0] v);
        return (v != '0) && ((v & (v - TAG_SIZE'(1))) == '0);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(TAG_SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    logic                 pop, push, alloc_err, res_err;
    logic [DIV_COUNT-1:0] dup, accept;
    logic [TAG_SIZE-1:0]  set_filled;
    logic [PW-1:0]        cand_ptr;
    logic [TAG_SIZE-1:0]  cand_tag;
    logic [DW-1:0]        cand_data;
    logic                 cand_avail, cand_ready, load;

    assign alloc_ready = (count < CW'(TAG_SIZE));
    assign pop         = out_valid && out_ready;
    assign push        = alloc_valid && alloc_ready && is_onehot(alloc_tag)
                         && ((alloc_tag & outstanding) == '0);
    assign alloc_err   = alloc_valid && !push;
    // Gated by reset so a reset landing on a handshake cycle never frees a tag.
    assign tag_free    = (pop && !reset) ? out_tag : '0;

    always_comb begin
        dup        = '0;
        accept     = '0;
        set_filled = '0;
        res_err    = 1'b0;
        for (int p = 0; p < DIV_COUNT; p++) begin
            for (int q = 0; q < p; q++) begin
                if (res_valid[q] && (res_tag[q] == res_tag[p])) dup[p] = 1'b1;
            end
            accept[p] = res_valid[p] && !dup[p] && is_onehot(res_tag[p])
                        && ((res_tag[p] & outstanding) != '0)
                        && ((res_tag[p] & filled) == '0);
            if (accept[p]) set_filled = set_filled | res_tag[p];
            if (res_valid[p] && !accept[p]) res_err = 1'b1;
        end
    end

    // While out_valid is set the output register already holds the head entry,
    // so the next load candidate is the entry behind it.
    assign cand_ptr   = out_valid ? next_ptr(rd_ptr) : rd_ptr;
    assign cand_avail = out_valid ? (count > CW'(1)) : (count != '0);
    assign cand_tag   = order_q[cand_ptr];

    always_comb begin
        cand_data  = '0;
        for (int t = 0; t < TAG_SIZE; t++) begin
            if (cand_tag[t]) cand_data = cand_data | slot[t];
        end
        cand_ready = ((cand_tag & filled) != '0);
`ifdef RCOL_BYPASS_EN
        for (int p = 0; p < DIV_COUNT; p++) begin
            if (accept[p] && (res_tag[p] == cand_tag)) begin
                cand_data  = res_data[p];
                cand_ready = 1'b1;
            end
        end
`endif
    end

    assign load = cand_avail && cand_ready && (!out_valid || out_ready);

    // Storage arrays carry no reset; their validity lives in count/filled.
    always_ff @(posedge clk) begin
        if (push) order_q[wr_ptr] <= alloc_tag;
        for (int p = 0; p < DIV_COUNT; p++) begin
            for (int t = 0; t < TAG_SIZE; t++) begin
                if (accept[p] && res_tag[p][t]) slot[t] <= res_data[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            filled      <= '0;
            out_valid   <= 1'b0;
            out_tag     <= '0;
            out_data    <= '0;
            err         <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            outstanding <= (outstanding | (push ? alloc_tag : '0)) & ~(pop ? out_tag : '0);
            filled      <= (filled | set_filled) & ~(pop ? out_tag : '0);
            if (load) begin
                out_valid <= 1'b1;
                out_tag   <= cand_tag;
                out_data  <= cand_data;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (alloc_err || res_err) err <= 1'b1;
        end
    end
endmodule
